exe_issue: RTL and testbench
============================

# exe_issue

Decode-to-execute issue register of the SCHOLAR RISC-V core. It accepts decoded instructions with a valid/ready handshake and selects the ALU operands: op1 is RS1, PC or zero; op2 is RS2 or the immediate. It resolves RS1/RS2 data hazards by forwarding from the mem and writeback stages. A two-entry skid buffer drives `ctrl`/`op1`/`op2` to the ALU at full throughput without a combinational ready path.

## Interface
Parameters:
- `DATA_WIDTH`, 32: operand width, 32 or 64.
- `EXE_CTRL_WIDTH`, 5: ALU control width. Value 0 means "no operation"; bit 4 marks word operations.

Ports:
- `clk_i` in 1: core clock, all state on rising edge.
- `rstn_i` in 1: reset. One clock; reset is asynchronous and active-low.
- `flush_i` in 1: discard all buffered entries.
- `dec_valid_i` in 1 / `dec_ready_o` out 1: upstream handshake.
- `dec_ctrl_i` in EXE_CTRL_WIDTH: ALU operation.
- `dec_op1_sel_i` in 2: op1 source. 00 RS1, 01 PC, 10 zero, 11 reserved and treated as zero.
- `dec_op2_sel_i` in 1: op2 source. 0 RS2, 1 immediate.
- `dec_rs1_i`, `dec_rs2_i` in 5: source register indices.
- `dec_rs1_data_i`, `dec_rs2_data_i`, `dec_pc_i`, `dec_imm_i` in DATA_WIDTH: register file read data, PC and sign-extended immediate.
- `mem_fwd_valid_i` in 1, `mem_fwd_rd_i` in 5, `mem_fwd_data_i` in DATA_WIDTH: mem-stage result.
- `wb_fwd_valid_i` in 1, `wb_fwd_rd_i` in 5, `wb_fwd_data_i` in DATA_WIDTH: writeback-stage result.
- `exe_valid_o` out 1 / `exe_ready_i` in 1: downstream handshake.
- `exe_ctrl_o` out EXE_CTRL_WIDTH, `exe_op1_o` out DATA_WIDTH, `exe_op2_o` out DATA_WIDTH: ALU inputs.
- `exe_rs2_data_o` out DATA_WIDTH: resolved RS2, used as store data.

## Operation
- **Entries.** There are two entries, main and skid. Each entry stores: ctrl, op1_sel, op2_sel, rs1, rs2, rs1_data, rs2_data, pc, imm.
- **Outputs.** All outputs come from the main entry:
  - `exe_valid_o` = main valid.
  - `exe_op1_o` and `exe_op2_o` are muxed combinationally from the stored fields according to the select fields.
  - `exe_rs2_data_o` = stored rs2_data.
- **Ready.** `dec_ready_o` = NOT skid valid.
- **Accept.** A beat is accepted when `dec_valid_i` && `dec_ready_o`.
  - If the main entry is empty, or will be consumed this cycle (`exe_ready_i`) while the skid entry is empty, the beat loads main.
  - Otherwise it loads skid.
- **Consume.** A beat is consumed when `exe_valid_o` && `exe_ready_i`. The skid entry moves to main if it is valid, else main empties, or main reloads from the input per the accept rule.
- **Order.** Strict FIFO order is kept.
- **Bubbles.** An accepted beat with `dec_ctrl_i == 0` is accepted and discarded. It is never presented downstream.
- **Forwarding at capture.** For each of rs1 and rs2:
  - The mem source is used if `mem_fwd_valid_i` and `mem_fwd_rd_i` equals the index.
  - Otherwise the wb source is used if `wb_fwd_valid_i` and `wb_fwd_rd_i` equals the index.
  - Otherwise the register file data is used.
  - Index 0 never forwards and always resolves to 0.
- **Forwarding refresh.** Every cycle, each held valid entry re-applies the same match and overwrites its rs1_data/rs2_data on a hit. A stalled instruction therefore picks up a producer that reaches mem or wb while it waits.
- **Flush.** `flush_i` clears both valid bits at the next edge. It takes priority over capture and skid transfer in the same cycle.
- **Data width.** No arithmetic is performed; all data paths are DATA_WIDTH wide.

## Timing
- **Reset.** While `rstn_i` is low: `exe_valid_o` = 0, `dec_ready_o` = 1, all data outputs and `exe_ctrl_o` = 0, both entries invalid. Reset asserted mid-transfer drops all entries immediately.
- **Latency.** A beat accepted at edge N with an empty buffer appears on `exe_valid_o` right after edge N, i.e. one cycle of latency.
- **Throughput.** One beat per cycle when `exe_ready_i` stays high.
- **Ready timing.** `dec_ready_o` depends only on registered state; it has no combinational path from `exe_ready_i`.
- **Full buffer.** With both entries full, `dec_ready_o` = 0. It returns to 1 the cycle after a consume.
- **Output stability.** While `exe_valid_o` && !`exe_ready_i`, `exe_ctrl_o` and the selects hold. Operand data may change only through a forwarding refresh.
- **Stale outputs.** After an entry is consumed with nothing behind it, the data outputs hold their last values; `exe_valid_o` = 0.
- **Flush with input.** `flush_i` together with `dec_valid_i` discards the input beat; `dec_ready_o` reads 1 the next cycle.

## Configuration
- Feature macro: `EXE_ISSUE_FWD_EN`.
- **Defined:** forwarding at capture and forwarding refresh as specified above.
- **Undefined:**
  - Forwarding ports are ignored.
  - rs1_data/rs2_data are captured from `dec_rs*_data_i` only and never refreshed.
  - Hazards are resolved by upstream stalling.

## Test plan
1. **Basic issue.** Reset, then accept ctrl=ADD, op1_sel=RS1, op2_sel=IMM, rs1_data=0x10, imm=0x5, with `exe_ready_i`=1. Next cycle: `exe_valid_o`=1, op1=0x10, op2=0x5.
2. **Back-pressure.** Hold `exe_ready_i`=0 and send 3 beats (ctrl 1, 2, 3). `dec_ready_o` drops after the 2nd accept. Raise `exe_ready_i`: outputs ctrl 1, 2, 3 in order on consecutive cycles, with no loss or duplication.
3. **Forward priority.** rs1=5, mem_fwd rd=5 data=0xAA, wb_fwd rd=5 data=0xBB → op1=0xAA. Same stimulus with rd=0 and rs1=0 → op1=0.
4. **Refresh while stalled.** A stalled entry has rs2=7 and rs2_data=0x1. wb_fwd rd=7 data=0x99 pulses for one cycle → `exe_rs2_data_o`=0x99 on the following cycle and it holds. With `EXE_ISSUE_FWD_EN` undefined it stays 0x1.
5. **Flush.** Both entries full, then `flush_i`=1 together with `dec_valid_i`=1 → next cycle `exe_valid_o`=0, `dec_ready_o`=1, and no beat is issued afterward.
6. **Bubble and PC select.** A beat with ctrl=0 is never issued. ctrl=ADD with op1_sel=PC (pc=0x100) and op2_sel=IMM (imm=4) → op1=0x100, op2=0x4.

Source files
------------

// File: rtl/exe_issue.sv
// ---------------------------------------------------------------------------
// exe_issue -- decode-to-execute issue register (two-entry skid buffer)
//
// Holds up to two decoded instructions (main + skid) between decode and the
// ALU. Selects ALU operands from the head entry and resolves RS1/RS2 hazards
// by forwarding from the mem and writeback stages.
//
// Optional feature macro: EXE_ISSUE_FWD_EN
//   defined   : forwarding at capture and per-cycle refresh of held entries
//   undefined : forwarding ports ignored, register data captured as-is
//
// Ports:
//   clk_i, rstn_i          clock, asynchronous active-low reset
//   flush_i                drop every buffered entry at the next edge
//   dec_valid_i/ready_o    upstream handshake
//   dec_*_i                decoded instruction fields and operand sources
//   mem_fwd_*_i, wb_fwd_*_i  forwarding sources (mem has priority)
//   exe_valid_o/ready_i    downstream handshake
//   exe_ctrl_o, exe_op1_o, exe_op2_o  ALU inputs
//   exe_rs2_data_o         resolved RS2 (store data)
// ---------------------------------------------------------------------------
module exe_issue #(
  parameter int DATA_WIDTH     = 32,
  parameter int EXE_CTRL_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      flush_i,
  input  logic                      dec_valid_i,
  output logic                      dec_ready_o,
  input  logic [EXE_CTRL_WIDTH-1:0] dec_ctrl_i,
  input  logic [1:0]                dec_op1_sel_i,
  input  logic                      dec_op2_sel_i,
  input  logic [4:0]                dec_rs1_i,
  input  logic [4:0]                dec_rs2_i,
  input  logic [DATA_WIDTH-1:0]     dec_rs1_data_i,
  input  logic [DATA_WIDTH-1:0]     dec_rs2_data_i,
  input  logic [DATA_WIDTH-1:0]     dec_pc_i,
  input  logic [DATA_WIDTH-1:0]     dec_imm_i,
  input  logic                      mem_fwd_valid_i,
  input  logic [4:0]                mem_fwd_rd_i,
  input  logic [DATA_WIDTH-1:0]     mem_fwd_data_i,
  input  logic                      wb_fwd_valid_i,
  input  logic [4:0]                wb_fwd_rd_i,
  input  logic [DATA_WIDTH-1:0]     wb_fwd_data_i,
  output logic                      exe_valid_o,
  input  logic                      exe_ready_i,
  output logic [EXE_CTRL_WIDTH-1:0] exe_ctrl_o,
  output logic [DATA_WIDTH-1:0]     exe_op1_o,
  output logic [DATA_WIDTH-1:0]     exe_op2_o,
  output logic [DATA_WIDTH-1:0]     exe_rs2_data_o
);

  typedef struct packed {
    logic [EXE_CTRL_WIDTH-1:0] ctrl;
    logic [1:0]                op1_sel;
    logic                      op2_sel;
    logic [4:0]                rs1;
    logic [4:0]                rs2;
    logic [DATA_WIDTH-1:0]     rs1_data;
    logic [DATA_WIDTH-1:0]     rs2_data;
    logic [DATA_WIDTH-1:0]     pc;
    logic [DATA_WIDTH-1:0]     imm;
  } entry_t;

  entry_t main_q, main_d, skid_q, skid_d;
  entry_t in_s, main_ref_s, skid_ref_s;
  logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic   consume_s, load_s;

`ifdef EXE_ISSUE_FWD_EN
  // x0 never forwards; mem beats wb; otherwise keep the supplied value.
  function automatic logic [DATA_WIDTH-1:0] resolve(
    input logic [4:0]            idx,
    input logic [DATA_WIDTH-1:0] base,
    input logic                  m_v,
    input logic [4:0]            m_rd,
    input logic [DATA_WIDTH-1:0] m_d,
    input logic                  w_v,
    input logic [4:0]            w_rd,
    input logic [DATA_WIDTH-1:0] w_d
  );
    logic [DATA_WIDTH-1:0] r;
    if (idx == 5'd0) begin
      r = {DATA_WIDTH{1'b0}};
    end else if (m_v && (m_rd == idx)) begin
      r = m_d;
    end else if (w_v && (w_rd == idx)) begin
      r = w_d;
    end else begin
      r = base;
    end
    return r;
  endfunction
`else
  logic unused_fwd_s;
  assign unused_fwd_s = ^{mem_fwd_valid_i, mem_fwd_rd_i, mem_fwd_data_i,
                          wb_fwd_valid_i, wb_fwd_rd_i, wb_fwd_data_i};
`endif

  // Ready comes straight from a flop: no path from exe_ready_i.
  assign dec_ready_o = ~skid_valid_q;
  assign consume_s   = main_valid_q & exe_ready_i;
  // ctrl == 0 beats are handshaken but never stored (bubble removal).
  assign load_s      = dec_valid_i & ~skid_valid_q &
                       (dec_ctrl_i != {EXE_CTRL_WIDTH{1'b0}});

  // Assemble the incoming entry with capture-time operand resolution
  always_comb begin
    in_s.ctrl    = dec_ctrl_i;
    in_s.op1_sel = dec_op1_sel_i;
    in_s.op2_sel = dec_op2_sel_i;
    in_s.rs1     = dec_rs1_i;
    in_s.rs2     = dec_rs2_i;
    in_s.pc      = dec_pc_i;
    in_s.imm     = dec_imm_i;
`ifdef EXE_ISSUE_FWD_EN
    in_s.rs1_data = resolve(dec_rs1_i, dec_rs1_data_i, mem_fwd_valid_i, mem_fwd_rd_i,
                            mem_fwd_data_i, wb_fwd_valid_i, wb_fwd_rd_i, wb_fwd_data_i);
    in_s.rs2_data = resolve(dec_rs2_i, dec_rs2_data_i, mem_fwd_valid_i, mem_fwd_rd_i,
                            mem_fwd_data_i, wb_fwd_valid_i, wb_fwd_rd_i, wb_fwd_data_i);
`else
    in_s.rs1_data = dec_rs1_data_i;
    in_s.rs2_data = dec_rs2_data_i;
`endif
  end

  // Refresh operand data of held valid entries; invalid entries keep stale data
  always_comb begin
    main_ref_s = main_q;
    skid_ref_s = skid_q;
`ifdef EXE_ISSUE_FWD_EN
    if (main_valid_q) begin
      main_ref_s.rs1_data = resolve(main_q.rs1, main_q.rs1_data, mem_fwd_valid_i, mem_fwd_rd_i,
                                    mem_fwd_data_i, wb_fwd_valid_i, wb_fwd_rd_i, wb_fwd_data_i);
      main_ref_s.rs2_data = resolve(main_q.rs2, main_q.rs2_data, mem_fwd_valid_i, mem_fwd_rd_i,
                                    mem_fwd_data_i, wb_fwd_valid_i, wb_fwd_rd_i, wb_fwd_data_i);
    end else begin
      main_ref_s = main_q;
    end
    if (skid_valid_q) begin
      skid_ref_s.rs1_data = resolve(skid_q.rs1, skid_q.rs1_data, mem_fwd_valid_i, mem_fwd_rd_i,
                                    mem_fwd_data_i, wb_fwd_valid_i, wb_fwd_rd_i, wb_fwd_data_i);
      skid_ref_s.rs2_data = resolve(skid_q.rs2, skid_q.rs2_data, mem_fwd_valid_i, mem_fwd_rd_i,
                                    mem_fwd_data_i, wb_fwd_valid_i, wb_fwd_rd_i, wb_fwd_data_i);
    end else begin
      skid_ref_s = skid_q;
    end
`endif
  end

  // Next-state of both entries: flush, main load, skid-to-main move, skid load
  always_comb begin
    main_d       = main_ref_s;
    skid_d       = skid_ref_s;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || (consume_s && !skid_valid_q)) begin
      // Main is free this edge: it takes the input (or empties).
      main_valid_d = load_s;
      if (load_s) begin
        main_d = in_s;
      end else begin
        main_d = main_ref_s;
      end
    end else if (consume_s) begin
      // Skid is valid here, so ready was low and no input is taken.
      main_d       = skid_ref_s;
      main_valid_d = 1'b1;
      skid_valid_d = 1'b0;
    end else begin
      // Main stalls; an accepted beat parks in the (empty) skid entry.
      if (load_s) begin
        skid_d       = in_s;
        skid_valid_d = 1'b1;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end
  end

  // State registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      main_q       <= {$bits(entry_t){1'b0}};
      skid_q       <= {$bits(entry_t){1'b0}};
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // ALU operand selection from the head entry
  always_comb begin
    case (main_q.op1_sel)
      2'b00:   exe_op1_o = main_q.rs1_data;
      2'b01:   exe_op1_o = main_q.pc;
      default: exe_op1_o = {DATA_WIDTH{1'b0}};
    endcase
    if (main_q.op2_sel) begin
      exe_op2_o = main_q.imm;
    end else begin
      exe_op2_o = main_q.rs2_data;
    end
  end

  assign exe_valid_o    = main_valid_q;
  assign exe_ctrl_o     = main_q.ctrl;
  assign exe_rs2_data_o = main_q.rs2_data;

endmodule

// File: tb/tb_exe_issue.sv
module tb_exe_issue;

`ifdef EXE_ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn_i, flush_i, dec_valid_i, dec_ready_o, dec_op2_sel_i;
  logic [4:0]  dec_ctrl_i, dec_rs1_i, dec_rs2_i;
  logic [1:0]  dec_op1_sel_i;
  logic [31:0] dec_rs1_data_i, dec_rs2_data_i, dec_pc_i, dec_imm_i;
  logic        mem_fwd_valid_i, wb_fwd_valid_i;
  logic [4:0]  mem_fwd_rd_i, wb_fwd_rd_i;
  logic [31:0] mem_fwd_data_i, wb_fwd_data_i;
  logic        exe_valid_o, exe_ready_i;
  logic [4:0]  exe_ctrl_o;
  logic [31:0] exe_op1_o, exe_op2_o, exe_rs2_data_o;

  exe_issue #(.DATA_WIDTH(32), .EXE_CTRL_WIDTH(5)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .flush_i(flush_i),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .dec_ctrl_i(dec_ctrl_i), .dec_op1_sel_i(dec_op1_sel_i), .dec_op2_sel_i(dec_op2_sel_i),
    .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i),
    .dec_rs1_data_i(dec_rs1_data_i), .dec_rs2_data_i(dec_rs2_data_i),
    .dec_pc_i(dec_pc_i), .dec_imm_i(dec_imm_i),
    .mem_fwd_valid_i(mem_fwd_valid_i), .mem_fwd_rd_i(mem_fwd_rd_i), .mem_fwd_data_i(mem_fwd_data_i),
    .wb_fwd_valid_i(wb_fwd_valid_i), .wb_fwd_rd_i(wb_fwd_rd_i), .wb_fwd_data_i(wb_fwd_data_i),
    .exe_valid_o(exe_valid_o), .exe_ready_i(exe_ready_i),
    .exe_ctrl_o(exe_ctrl_o), .exe_op1_o(exe_op1_o), .exe_op2_o(exe_op2_o),
    .exe_rs2_data_o(exe_rs2_data_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: an in-order queue of at most 2 beats
  typedef struct {
    logic [4:0]  ctrl;
    logic [1:0]  s1;
    logic        s2;
    logic [4:0]  rs1, rs2;
    logic [31:0] d1, d2, pc, imm;
  } beat_t;

  beat_t mq[$];

  function automatic logic [31:0] res(input logic [4:0] idx, input logic [31:0] base);
`ifdef EXE_ISSUE_FWD_EN
    if (idx == 5'd0) return 32'd0;
    if (mem_fwd_valid_i && mem_fwd_rd_i == idx) return mem_fwd_data_i;
    if (wb_fwd_valid_i && wb_fwd_rd_i == idx) return wb_fwd_data_i;
`endif
    return base;
  endfunction

  function automatic logic [31:0] op1_of(input beat_t b);
    if (b.s1 == 2'd0) return b.d1;
    if (b.s1 == 2'd1) return b.pc;
    return 32'd0;
  endfunction

  function automatic logic [31:0] op2_of(input beat_t b);
    return b.s2 ? b.imm : b.d2;
  endfunction

  always @(posedge clk) begin
    bit    room;
    beat_t b;
    if (!rstn_i || flush_i) begin
      mq.delete();
    end else begin
      room = (mq.size() < 2);
      if (mq.size() > 0 && exe_ready_i) void'(mq.pop_front());
      foreach (mq[i]) begin
        mq[i].d1 = res(mq[i].rs1, mq[i].d1);
        mq[i].d2 = res(mq[i].rs2, mq[i].d2);
      end
      if (dec_valid_i && room && dec_ctrl_i != 5'd0) begin
        b.ctrl = dec_ctrl_i; b.s1 = dec_op1_sel_i; b.s2 = dec_op2_sel_i;
        b.rs1 = dec_rs1_i; b.rs2 = dec_rs2_i;
        b.d1 = res(dec_rs1_i, dec_rs1_data_i);
        b.d2 = res(dec_rs2_i, dec_rs2_data_i);
        b.pc = dec_pc_i; b.imm = dec_imm_i;
        mq.push_back(b);
      end
    end
  end

  // Every-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    chk("m_valid", {31'd0, exe_valid_o}, {31'd0, mq.size() > 0});
    chk("m_ready", {31'd0, dec_ready_o}, {31'd0, mq.size() < 2});
    if (mq.size() > 0) begin
      chk("m_ctrl", {27'd0, exe_ctrl_o}, {27'd0, mq[0].ctrl});
      chk("m_op1", exe_op1_o, op1_of(mq[0]));
      chk("m_op2", exe_op2_o, op2_of(mq[0]));
      chk("m_rs2d", exe_rs2_data_o, mq[0].d2);
    end
  end

  // ---------------- stimulus helpers
  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic idle_in();
    dec_valid_i = 1'b0; flush_i = 1'b0;
    mem_fwd_valid_i = 1'b0; wb_fwd_valid_i = 1'b0;
  endtask

  task automatic drive(input logic [4:0] ctrl, input logic [1:0] s1, input logic s2,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] pc, input logic [31:0] imm);
    dec_valid_i = 1'b1; dec_ctrl_i = ctrl; dec_op1_sel_i = s1; dec_op2_sel_i = s2;
    dec_rs1_i = rs1; dec_rs2_i = rs2; dec_rs1_data_i = d1; dec_rs2_data_i = d2;
    dec_pc_i = pc; dec_imm_i = imm;
  endtask

  initial begin
    rstn_i = 1'b0; exe_ready_i = 1'b0;
    idle_in();
    drive(5'd0, 2'd0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    dec_valid_i = 1'b0;
    mem_fwd_rd_i = 5'd0; mem_fwd_data_i = 32'd0; wb_fwd_rd_i = 5'd0; wb_fwd_data_i = 32'd0;
    step(); step();
    chk("rst_valid", {31'd0, exe_valid_o}, 32'd0);
    chk("rst_ready", {31'd0, dec_ready_o}, 32'd1);
    chk("rst_ctrl", {27'd0, exe_ctrl_o}, 32'd0);
    chk("rst_op1", exe_op1_o, 32'd0);
    chk("rst_op2", exe_op2_o, 32'd0);
    chk("rst_rs2d", exe_rs2_data_o, 32'd0);
    rstn_i = 1'b1;
    step();

    // 1. basic issue, one-cycle latency
    exe_ready_i = 1'b1;
    drive(5'd1, 2'b00, 1'b1, 5'd1, 5'd2, 32'h10, 32'h77, 32'h0, 32'h5);
    step(); idle_in();
    chk("basic_valid", {31'd0, exe_valid_o}, 32'd1);
    chk("basic_op1", exe_op1_o, 32'h10);
    chk("basic_op2", exe_op2_o, 32'h5);
    step();
    chk("basic_drain", {31'd0, exe_valid_o}, 32'd0);
    chk("stale_op1", exe_op1_o, 32'h10);

    // 2. back-pressure and FIFO order
    exe_ready_i = 1'b0;
    drive(5'd1, 2'b10, 1'b1, 5'd3, 5'd4, 32'h0, 32'h0, 32'h0, 32'h101);
    step();
    chk("bp_ready1", {31'd0, dec_ready_o}, 32'd1);
    drive(5'd2, 2'b10, 1'b1, 5'd3, 5'd4, 32'h0, 32'h0, 32'h0, 32'h102);
    step();
    chk("bp_ready2", {31'd0, dec_ready_o}, 32'd0);
    drive(5'd3, 2'b10, 1'b1, 5'd3, 5'd4, 32'h0, 32'h0, 32'h0, 32'h103);
    step();
    chk("bp_hold_ctrl", {27'd0, exe_ctrl_o}, 32'd1);
    exe_ready_i = 1'b1;
    step();
    chk("bp_out2", {27'd0, exe_ctrl_o}, 32'd2);
    chk("bp_ready_back", {31'd0, dec_ready_o}, 32'd1);
    step(); idle_in();
    chk("bp_out3", {27'd0, exe_ctrl_o}, 32'd3);
    chk("bp_out3_imm", exe_op2_o, 32'h103);
    step();
    chk("bp_empty", {31'd0, exe_valid_o}, 32'd0);

    // 3. forwarding priority at capture
    drive(5'd1, 2'b00, 1'b0, 5'd5, 5'd6, 32'h11, 32'h66, 32'h0, 32'h0);
    mem_fwd_valid_i = 1'b1; mem_fwd_rd_i = 5'd5; mem_fwd_data_i = 32'hAA;
    wb_fwd_valid_i = 1'b1; wb_fwd_rd_i = 5'd5; wb_fwd_data_i = 32'hBB;
    step(); idle_in();
    chk("fwd_mem_prio", exe_op1_o, FWD ? 32'hAA : 32'h11);
    drive(5'd1, 2'b00, 1'b0, 5'd9, 5'd6, 32'h12, 32'h66, 32'h0, 32'h0);
    mem_fwd_valid_i = 1'b1; mem_fwd_rd_i = 5'd9; mem_fwd_data_i = 32'hA1;
    wb_fwd_valid_i = 1'b1; wb_fwd_rd_i = 5'd6; wb_fwd_data_i = 32'hCC;
    step(); idle_in();
    chk("fwd_wb_rs2", exe_op2_o, FWD ? 32'hCC : 32'h66);
    drive(5'd1, 2'b00, 1'b0, 5'd0, 5'd6, 32'h22, 32'h66, 32'h0, 32'h0);
    mem_fwd_valid_i = 1'b1; mem_fwd_rd_i = 5'd0; mem_fwd_data_i = 32'hAA;
    wb_fwd_valid_i = 1'b1; wb_fwd_rd_i = 5'd0; wb_fwd_data_i = 32'hBB;
    step(); idle_in();
    chk("fwd_x0", exe_op1_o, FWD ? 32'h0 : 32'h22);
    step();

    // 4. refresh while stalled
    exe_ready_i = 1'b0;
    drive(5'd2, 2'b00, 1'b0, 5'd3, 5'd7, 32'h3, 32'h1, 32'h0, 32'h0);
    step(); idle_in();
    chk("ref_before", exe_rs2_data_o, 32'h1);
    wb_fwd_valid_i = 1'b1; wb_fwd_rd_i = 5'd7; wb_fwd_data_i = 32'h99;
    step(); idle_in();
    chk("ref_after", exe_rs2_data_o, FWD ? 32'h99 : 32'h1);
    chk("ref_ctrl_hold", {27'd0, exe_ctrl_o}, 32'd2);
    step();
    chk("ref_holds", exe_rs2_data_o, FWD ? 32'h99 : 32'h1);
    exe_ready_i = 1'b1;
    step();

    // 5. flush with both entries full and an input beat
    exe_ready_i = 1'b0;
    drive(5'd4, 2'b10, 1'b1, 5'd1, 5'd1, 32'h0, 32'h0, 32'h0, 32'h4);
    step();
    drive(5'd5, 2'b10, 1'b1, 5'd1, 5'd1, 32'h0, 32'h0, 32'h0, 32'h5);
    step();
    chk("fl_full", {31'd0, dec_ready_o}, 32'd0);
    drive(5'd6, 2'b10, 1'b1, 5'd1, 5'd1, 32'h0, 32'h0, 32'h0, 32'h6);
    flush_i = 1'b1;
    step(); idle_in();
    chk("fl_valid", {31'd0, exe_valid_o}, 32'd0);
    chk("fl_ready", {31'd0, dec_ready_o}, 32'd1);
    exe_ready_i = 1'b1;
    step(); step();
    chk("fl_no_issue", {31'd0, exe_valid_o}, 32'd0);

    // 6. bubble and PC / reserved select
    drive(5'd0, 2'b00, 1'b0, 5'd1, 5'd1, 32'h1, 32'h1, 32'h0, 32'h0);
    step(); idle_in();
    chk("bubble", {31'd0, exe_valid_o}, 32'd0);
    drive(5'd1, 2'b01, 1'b1, 5'd1, 5'd1, 32'h1, 32'h1, 32'h100, 32'h4);
    step(); idle_in();
    chk("pc_op1", exe_op1_o, 32'h100);
    chk("pc_op2", exe_op2_o, 32'h4);
    drive(5'd1, 2'b11, 1'b0, 5'd1, 5'd1, 32'h55, 32'h9, 32'h100, 32'h4);
    step(); idle_in();
    chk("rsv_op1", exe_op1_o, 32'h0);
    step();

    // Mixed directed pattern: stalls, bubbles, forwarding, one flush
    for (int i = 0; i < 40; i++) begin
      exe_ready_i = (i % 3) != 0;
      drive(5'(i % 5), 2'(i % 4), 1'(i % 2), 5'(i % 8), 5'((i + 3) % 8),
            32'h101 * i, 32'hFFFF0000 + i, 32'h1000 + 4 * i, 32'h20 + i);
      dec_valid_i = (i % 7) != 6;
      flush_i = (i == 17);
      mem_fwd_valid_i = (i % 2) == 1; mem_fwd_rd_i = 5'((i + 1) % 8); mem_fwd_data_i = 32'hA000 + i;
      wb_fwd_valid_i = (i % 3) == 1; wb_fwd_rd_i = 5'((i + 4) % 8); wb_fwd_data_i = 32'hB000 + i;
      step();
    end
    idle_in();
    exe_ready_i = 1'b1;
    step(); step(); step();

    // Asynchronous reset while both entries are full
    exe_ready_i = 1'b0;
    drive(5'd7, 2'b00, 1'b0, 5'd2, 5'd2, 32'h7, 32'h7, 32'h0, 32'h0);
    step();
    drive(5'd8, 2'b00, 1'b0, 5'd2, 5'd2, 32'h8, 32'h8, 32'h0, 32'h0);
    step(); idle_in();
    chk("pre_rst_valid", {31'd0, exe_valid_o}, 32'd1);
    #2 rstn_i = 1'b0;
    #1;
    chk("arst_valid", {31'd0, exe_valid_o}, 32'd0);
    chk("arst_ready", {31'd0, dec_ready_o}, 32'd1);
    chk("arst_op1", exe_op1_o, 32'd0);
    step();
    rstn_i = 1'b1;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
